// File: rtl/dense_scale_relu6_requant_if.sv
// Stream, scale-ROM and status bundle for dense_scale_relu6_requant.
// The slave modport is the requant block; master is whatever drives it
// (MAC array, scale ROM, activation buffer, or a testbench).
interface dense_scale_relu6_requant_if #(
  parameter int ACC_W = 32
);
  logic                    start;
  logic signed [ACC_W-1:0] acc_data;
  logic                    acc_valid;
  logic                    acc_ready;
  logic [7:0]              scale_addr;
  logic [7:0]              scale_data;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    busy;
  logic                    done;
  logic [7:0]              sat_count;

  modport slave (
    input  start, acc_data, acc_valid, scale_data, out_ready,
    output acc_ready, scale_addr, out_data, out_valid, out_last,
           busy, done, sat_count
  );

  modport master (
    output start, acc_data, acc_valid, scale_data, out_ready,
    input  acc_ready, scale_addr, out_data, out_valid, out_last,
           busy, done, sat_count
  );
endinterface

// File: rtl/dense_scale_relu6_requant.sv
// Per-channel BN scale, round/shift and ReLU6 clamp between the dense MAC
// array and the activation buffer. Two-stage pipeline: stage 1 registers
// the accumulator x scale product, stage 2 rounds, shifts and clamps.
// Optional macro DENSE_REQUANT_SAT_COUNT_EN enables the clamp-high counter
// on sat_count; without it sat_count is tied to zero.
module dense_scale_relu6_requant #(
  parameter int NUM_CH  = 128,
  parameter int ACC_W   = 32,
  parameter int SHIFT   = 7,
  parameter int RELU6_Q = 96
) (
  input  logic                         clk,
  input  logic                         rst,
  dense_scale_relu6_requant_if.slave   io
);

  localparam int PW = ACC_W + 9;
  localparam logic signed [PW-1:0] ROUND   = {{(PW-1){1'b0}}, 1'b1} << (SHIFT-1);
  localparam logic signed [PW-1:0] RELU6_S = PW'(RELU6_Q);
  localparam logic [7:0]           LAST_CH = 8'(NUM_CH-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [7:0]             ch_cnt;
  logic                   s1_valid;
  logic                   s1_last;
  logic signed [PW-1:0]   s1_prod;

  logic                   advance;
  logic                   s1_load;
  logic                   acc_hs;
  logic                   start_ok;
  logic signed [PW-1:0]   acc_ext;
  logic signed [PW-1:0]   scl_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   rnd;
  logic                   over;
  logic [7:0]             clamp;

  assign advance     = !io.out_valid | io.out_ready;
  assign s1_load     = advance | !s1_valid;
  assign io.acc_ready = (state == RUN) & (!s1_valid | advance);
  assign acc_hs      = io.acc_valid & io.acc_ready;
  assign start_ok    = (state == IDLE) & io.start;
  assign io.scale_addr = ch_cnt;
  assign io.busy     = (state != IDLE);

  // The scale is unsigned, so it gets a zero MSB before the signed multiply.
  assign acc_ext = {{9{io.acc_data[ACC_W-1]}}, io.acc_data};
  assign scl_ext = {{(PW-8){1'b0}}, io.scale_data};
  assign prod    = acc_ext * scl_ext;

  assign rnd  = (s1_prod + ROUND) >>> SHIFT;
  assign over = rnd > RELU6_S;

  // ReLU6 clamp of the rounded value into 0..RELU6_Q.
  always_comb begin
    clamp = rnd[7:0];
    if (rnd[PW-1])
      clamp = '0;
    else if (over)
      clamp = 8'(RELU6_Q);
  end

  // Pass control: IDLE waits for start, RUN accepts channels, DRAIN empties
  // the pipeline and pulses done once the last output is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      io.done <= 1'b0;
    end else begin
      io.done <= 1'b0;
      case (state)
        IDLE:    if (io.start) state <= RUN;
        RUN:     if (acc_hs && ch_cnt == LAST_CH) state <= DRAIN;
        DRAIN: begin
          if (io.out_valid && io.out_ready && io.out_last) begin
            state   <= IDLE;
            io.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel counter doubles as the ROM address; it parks on the last channel.
  always_ff @(posedge clk) begin
    if (rst)
      ch_cnt <= '0;
    else if (start_ok)
      ch_cnt <= '0;
    else if (acc_hs && ch_cnt != LAST_CH)
      ch_cnt <= ch_cnt + 8'd1;
  end

  // Stage 1 captures the product and last-channel tag on each acc handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (s1_load) begin
      s1_valid <= acc_hs;
      if (acc_hs) begin
        s1_prod <= prod;
        s1_last <= (ch_cnt == LAST_CH);
      end
    end
  end

  // Stage 2 output register; holds its contents while stalled downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.out_last  <= 1'b0;
    end else if (advance) begin
      io.out_valid <= s1_valid;
      if (s1_valid) begin
        io.out_data <= clamp;
        io.out_last <= s1_last;
      end
    end
  end

`ifdef DENSE_REQUANT_SAT_COUNT_EN
  logic [7:0] sat_q;

  // Counts upper-clamp events as they load into stage 2, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst)
      sat_q <= '0;
    else if (start_ok)
      sat_q <= '0;
    else if (advance && s1_valid && over && sat_q != 8'hFF)
      sat_q <= sat_q + 8'd1;
  end

  assign io.sat_count = sat_q;
`else
  assign io.sat_count = '0;
`endif

endmodule
